// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared MIPS32 encoding definitions used by the program loader and its
// matching control decoder: opcode and funct constants, the 3-bit op-class
// enum, the format field widths, the loader state enum and the encode helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

    // Format field widths
    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int TARGET_W = 26;
    localparam int INSTR_W  = 32;

    // Op classes as carried on req_op
    typedef enum logic [2:0] {
        OP_RTYPE = 3'd0,
        OP_ADDI  = 3'd1,
        OP_BEQ   = 3'd2,
        OP_BNE   = 3'd3,
        OP_LW    = 3'd4,
        OP_SW    = 3'd5,
        OP_SLTI  = 3'd6,
        OP_J     = 3'd7
    } op_class_e;

    // Primary opcodes
    localparam logic [OPCODE_W-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OPC_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OPC_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OPC_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OPC_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OPC_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OPC_SLTI  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OPC_J     = 6'b000010;

    // R-type function codes the decoder recognises
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

    // Loader states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input op_class_e op);
        logic [OPCODE_W-1:0] opc;
        case (op)
            OP_RTYPE: opc = OPC_RTYPE;
            OP_ADDI:  opc = OPC_ADDI;
            OP_BEQ:   opc = OPC_BEQ;
            OP_BNE:   opc = OPC_BNE;
            OP_LW:    opc = OPC_LW;
            OP_SW:    opc = OPC_SW;
            OP_SLTI:  opc = OPC_SLTI;
            OP_J:     opc = OPC_J;
            default:  opc = OPC_RTYPE;
        endcase
        return opc;
    endfunction

    // Builds the 32-bit word; fields the chosen format does not use are dropped.
    function automatic logic [INSTR_W-1:0] encode_word(
        input op_class_e            op,
        input logic [REG_W-1:0]     rs,
        input logic [REG_W-1:0]     rt,
        input logic [REG_W-1:0]     rd,
        input logic [SHAMT_W-1:0]   shamt,
        input logic [FUNCT_W-1:0]   funct,
        input logic [IMM_W-1:0]     imm,
        input logic [TARGET_W-1:0]  target
    );
        logic [INSTR_W-1:0] word;
        case (op)
            OP_RTYPE: word = {OPC_RTYPE, rs, rt, rd, shamt, funct};
            OP_J:     word = {OPC_J, target};
            default:  word = {opcode_of(op), rs, rt, imm};
        endcase
        return word;
    endfunction

    function automatic logic funct_is_legal(input logic [FUNCT_W-1:0] funct);
        logic ok;
        case (funct)
            FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Bundles the request handshake (host -> loader) and the instruction-memory
// write port (loader -> memory).
//   master : host/memory side (drives requests and imem_ready)
//   slave  : the loader (drives req_ready and the imem write strobe/addr/data)
// Parameter ADDR_W : instruction-memory word-address width.
// -----------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [4:0]        req_rs;
    logic [4:0]        req_rt;
    logic [4:0]        req_rd;
    logic [4:0]        req_shamt;
    logic [5:0]        req_funct;
    logic [15:0]       req_imm;
    logic [25:0]       req_target;
    logic              req_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ready;

    modport master (
        output req_valid, req_op, req_rs, req_rt, req_rd, req_shamt,
               req_funct, req_imm, req_target, req_last, imem_ready,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, req_rd, req_shamt,
               req_funct, req_imm, req_target, req_last, imem_ready,
        output req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_enc_fifo.sv
// -----------------------------------------------------------------------------
// instr_enc_fifo
// Synchronous DEPTH x WIDTH FIFO holding encoded words. Head word is shown
// combinationally on rdata; push is ignored when full, pop when empty.
// Ports: clk, rst_n (sync active-low, empties the FIFO), push, pop, wdata,
//        rdata, full, empty, level (occupancy).
// -----------------------------------------------------------------------------
module instr_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level
);
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign level     = wr_ptr_r - rd_ptr_r;
    assign full      = (level == (PTR_W+1)'(DEPTH));
    assign empty     = (level == {(PTR_W+1){1'b0}});
    assign rdata     = mem_r[rd_ptr_r[PTR_W-1:0]];

    // Pointer update; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; contents need no reset since empty gates their use.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Program loader: encodes field-level MIPS32 requests, queues them in a small
// FIFO and writes them to instruction memory at consecutive word addresses
// starting at base_addr.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, base_addr    begin a load (ignored while loading)
//   bus (slave)         request handshake + imem write port
//   busy, done          in LOAD / in DONE
//   word_count          words written since start
//   wrap                sticky: address wrapped during this load
//   err                 sticky illegal-request flag
// Optional build macro INSTR_ENC_CHECK_EN: R-type requests with a funct the
// decoder does not know are accepted but dropped and set err. Without it every
// request is encoded verbatim and err is tied low.
// -----------------------------------------------------------------------------
module instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    instr_encoder_if.slave    bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              wrap,
    output logic              err
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    enc_state_e         state_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [ADDR_W:0]    count_r;
    logic               wrap_r;
    logic               last_seen_r;

    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [LVL_W-1:0]   fifo_level_s;
    logic [INSTR_W-1:0] fifo_rdata_s;
    logic [INSTR_W-1:0] enc_word_s;

    logic               req_ready_s;
    logic               accept_s;
    logic               drop_s;
    logic               push_s;
    logic               pop_s;
    logic [LVL_W-1:0]   level_next_s;
    logic               last_next_s;
    logic               drained_s;

    // Handshake, drop decision and the next-cycle occupancy used to enter DONE.
    always_comb begin
        req_ready_s = (state_r == ST_LOAD) && !fifo_full_s && !last_seen_r;
        accept_s    = bus.req_valid && req_ready_s;
`ifdef INSTR_ENC_CHECK_EN
        drop_s      = (op_class_e'(bus.req_op) == OP_RTYPE) &&
                      !funct_is_legal(bus.req_funct);
`else
        drop_s      = 1'b0;
`endif
        push_s      = accept_s && !drop_s;
        pop_s       = !fifo_empty_s && bus.imem_ready;
        // DONE is entered straight after the last pop, so look one cycle ahead.
        level_next_s = fifo_level_s + LVL_W'(push_s) - LVL_W'(pop_s);
        last_next_s  = last_seen_r || (accept_s && bus.req_last);
        drained_s    = (level_next_s == {LVL_W{1'b0}});
        enc_word_s   = encode_word(op_class_e'(bus.req_op), bus.req_rs, bus.req_rt,
                                   bus.req_rd, bus.req_shamt, bus.req_funct,
                                   bus.req_imm, bus.req_target);
    end

    instr_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (enc_word_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // Loader FSM with write address, word counter and sticky wrap flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            count_r     <= {(ADDR_W+1){1'b0}};
            wrap_r      <= 1'b0;
            last_seen_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r     <= ST_LOAD;
                        addr_r      <= base_addr;
                        count_r     <= {(ADDR_W+1){1'b0}};
                        wrap_r      <= 1'b0;
                        last_seen_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (pop_s) begin
                        addr_r  <= addr_r + ADDR_W'(1);
                        count_r <= count_r + (ADDR_W+1)'(1);
                        if (addr_r == {ADDR_W{1'b1}}) begin
                            wrap_r <= 1'b1;
                        end
                    end
                    last_seen_r <= last_next_s;
                    if (last_next_s && drained_s) begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef INSTR_ENC_CHECK_EN
    logic err_r;

    // Sticky illegal-request flag, cleared by a start that begins a load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (start && (state_r != ST_LOAD)) begin
            err_r <= 1'b0;
        end else if (accept_s && drop_s) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign bus.req_ready  = req_ready_s;
    assign bus.imem_we    = !fifo_empty_s;
    assign bus.imem_addr  = addr_r;
    // Storage is not reset, so mask the head word while nothing is queued.
    assign bus.imem_wdata = fifo_empty_s ? {INSTR_W{1'b0}} : fifo_rdata_s;
    assign busy           = (state_r == ST_LOAD);
    assign done           = (state_r == ST_DONE);
    assign word_count     = count_r;
    assign wrap           = wrap_r;
endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Directed self-checking bench for instr_encoder (ADDR_W=8, DEPTH=4).
// -----------------------------------------------------------------------------
module tb_instr_encoder;
    import mips_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic       busy;
    logic       done;
    logic [8:0] word_count;
    logic       wrap;
    logic       err;

    int tests;
    int fails;

    logic [7:0]  wr_addr [$];
    logic [31:0] wr_data [$];

    instr_encoder_if #(.ADDR_W(8)) bus ();

    instr_encoder #(.ADDR_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .wrap       (wrap),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted memory write
    always @(posedge clk) begin
        if (rst_n && bus.imem_we && bus.imem_ready) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] b);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [25:0] tgt, input logic last);
        int n;
        @(negedge clk);
        bus.req_op     = op;
        bus.req_rs     = rs;
        bus.req_rt     = rt;
        bus.req_rd     = rd;
        bus.req_shamt  = sh;
        bus.req_funct  = fn;
        bus.req_imm    = imm;
        bus.req_target = tgt;
        bus.req_last   = last;
        bus.req_valid  = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", {63'd0, bus.req_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_done", {63'd0, done}, 64'd1);
    endtask

    initial begin
        int b;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = 8'd0;
        bus.req_valid = 1'b0;
        bus.req_op = 3'd0;
        bus.req_rs = 5'd0;
        bus.req_rt = 5'd0;
        bus.req_rd = 5'd0;
        bus.req_shamt = 5'd0;
        bus.req_funct = 6'd0;
        bus.req_imm = 16'd0;
        bus.req_target = 26'd0;
        bus.req_last = 1'b0;
        bus.imem_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
        check("rst_we", {63'd0, bus.imem_we}, 64'd0);
        check("rst_addr", {56'd0, bus.imem_addr}, 64'd0);
        check("rst_wdata", {32'd0, bus.imem_wdata}, 64'd0);
        check("rst_busy_done", {62'd0, busy, done}, 64'd0);
        check("rst_count", {55'd0, word_count}, 64'd0);
        check("rst_wrap_err", {62'd0, wrap, err}, 64'd0);
        rst_n = 1'b1;

        // Single ADDI at base 0x10
        b = wr_addr.size();
        do_start(8'h10);
        check("t1_busy", {63'd0, busy}, 64'd1);
        send(OP_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1);
        @(negedge clk);
        check("t1_we", {63'd0, bus.imem_we}, 64'd1);
        check("t1_wdata_live", {32'd0, bus.imem_wdata}, 64'h20220005);
        @(posedge clk);
        #1;
        check("t1_done_next", {63'd0, done}, 64'd1);
        check("t1_nwrites", 64'(wr_addr.size() - b), 64'd1);
        check("t1_addr", {56'd0, wr_addr[b]}, 64'h10);
        check("t1_data", {32'd0, wr_data[b]}, 64'h20220005);
        check("t1_count", {55'd0, word_count}, 64'd1);
        check("t1_busy_low", {63'd0, busy}, 64'd0);

        // R-type add followed by J
        b = wr_addr.size();
        do_start(8'h00);
        send(OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0);
        send(OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1);
        wait_done();
        check("t2_nwrites", 64'(wr_addr.size() - b), 64'd2);
        check("t2_addr0", {56'd0, wr_addr[b]}, 64'h00);
        check("t2_data0", {32'd0, wr_data[b]}, 64'h00221820);
        check("t2_addr1", {56'd0, wr_addr[b+1]}, 64'h01);
        check("t2_data1", {32'd0, wr_data[b+1]}, 64'h08000010);
        check("t2_count", {55'd0, word_count}, 64'd2);

        // Backpressure: fill the FIFO with imem_ready low, outputs must hold
        b = wr_addr.size();
        bus.imem_ready = 1'b0;
        do_start(8'h20);
        send(OP_LW, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0);
        send(OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
        send(OP_RTYPE, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22, 16'd0, 26'd0, 1'b0);
        send(OP_SLTI, 5'd3, 5'd7, 5'd0, 5'd0, 6'd0, 16'h8000, 26'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_full_ready", {63'd0, bus.req_ready}, 64'd0);
            check("t3_hold_we", {63'd0, bus.imem_we}, 64'd1);
            check("t3_hold_addr", {56'd0, bus.imem_addr}, 64'h20);
            check("t3_hold_data", {32'd0, bus.imem_wdata}, 64'h8FA80004);
        end
        bus.imem_ready = 1'b1;
        send(OP_SW, 5'd0, 5'd31, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b1);
        wait_done();
        check("t3_nwrites", 64'(wr_addr.size() - b), 64'd5);
        check("t3_data0", {32'd0, wr_data[b]}, 64'h8FA80004);
        check("t3_data1", {32'd0, wr_data[b+1]}, 64'h1022FFFF);
        check("t3_data2", {32'd0, wr_data[b+2]}, 64'h00853022);
        check("t3_data3", {32'd0, wr_data[b+3]}, 64'h28678000);
        check("t3_data4", {32'd0, wr_data[b+4]}, 64'hAC1F0010);
        check("t3_addr4", {56'd0, wr_addr[b+4]}, 64'h24);
        check("t3_count", {55'd0, word_count}, 64'd5);
        check("t3_nowrap", {63'd0, wrap}, 64'd0);

        // Address wrap from 0xFF to 0x00
        b = wr_addr.size();
        do_start(8'hFE);
        send(OP_BNE, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
        send(OP_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0007, 26'd0, 1'b0);
        send(OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FFFFFF, 1'b1);
        wait_done();
        check("t4_nwrites", 64'(wr_addr.size() - b), 64'd3);
        check("t4_addr0", {56'd0, wr_addr[b]}, 64'hFE);
        check("t4_addr1", {56'd0, wr_addr[b+1]}, 64'hFF);
        check("t4_addr2", {56'd0, wr_addr[b+2]}, 64'h00);
        check("t4_data0", {32'd0, wr_data[b]}, 64'h14430001);
        check("t4_data1", {32'd0, wr_data[b+1]}, 64'h20010007);
        check("t4_data2", {32'd0, wr_data[b+2]}, 64'h0BFFFFFF);
        check("t4_wrap", {63'd0, wrap}, 64'd1);
        check("t4_count", {55'd0, word_count}, 64'd3);

        // Illegal R-type funct
        b = wr_addr.size();
        do_start(8'h40);
        check("t5_wrap_clr", {63'd0, wrap}, 64'd0);
        check("t5_count_clr", {55'd0, word_count}, 64'd0);
        send(OP_RTYPE, 5'd0, 5'd0, 5'd0, 5'd0, 6'h3F, 16'd0, 26'd0, 1'b1);
        wait_done();
`ifdef INSTR_ENC_CHECK_EN
        check("t5_nwrites", 64'(wr_addr.size() - b), 64'd0);
        check("t5_err", {63'd0, err}, 64'd1);
        check("t5_count", {55'd0, word_count}, 64'd0);
`else
        check("t5_nwrites", 64'(wr_addr.size() - b), 64'd1);
        check("t5_addr", {56'd0, wr_addr[b]}, 64'h40);
        check("t5_data", {32'd0, wr_data[b]}, 64'h0000003F);
        check("t5_err", {63'd0, err}, 64'd0);
        check("t5_count", {55'd0, word_count}, 64'd1);
`endif

        // Reset in mid-load with 3 words queued
        bus.imem_ready = 1'b0;
        do_start(8'h50);
        send(OP_ADDI, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0);
        send(OP_ADDI, 5'd2, 5'd2, 5'd0, 5'd0, 6'd0, 16'd2, 26'd0, 1'b0);
        send(OP_ADDI, 5'd3, 5'd3, 5'd0, 5'd0, 6'd0, 16'd3, 26'd0, 1'b0);
        @(negedge clk);
        check("t6_queued_we", {63'd0, bus.imem_we}, 64'd1);
        b = wr_addr.size();
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_we", {63'd0, bus.imem_we}, 64'd0);
        check("t6_rst_ready", {63'd0, bus.req_ready}, 64'd0);
        check("t6_rst_addr", {56'd0, bus.imem_addr}, 64'd0);
        check("t6_rst_wdata", {32'd0, bus.imem_wdata}, 64'd0);
        check("t6_rst_state", {62'd0, busy, done}, 64'd0);
        check("t6_rst_count", {55'd0, word_count}, 64'd0);
        rst_n = 1'b1;
        bus.imem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_no_we", {63'd0, bus.imem_we}, 64'd0);
        end
        check("t6_nwrites", 64'(wr_addr.size() - b), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
